// File: rtl/kurm_exec_unit.sv
// kurm_exec_unit: single-cycle decode, ALU and word-addressed data memory.
// Define KURM_ALU_FLAGS_EN to drive c_out/lt/gt/overflow; otherwise they read 0.
module kurm_exec_unit #(
   parameter int DMEM_DEPTH = 64
) (
   input  logic        clock,
   input  logic        clearN,
   input  logic [3:0]  opcode,
   input  logic [15:0] rs_data,
   input  logic [15:0] rt_data,
   input  logic [3:0]  imm4,
   input  logic        c_in,
   output logic        reg_dst,
   output logic        jump,
   output logic        branch,
   output logic        mem_read,
   output logic        mem_to_reg,
   output logic        mem_write,
   output logic        alu_src,
   output logic        reg_write,
   output logic [2:0]  alu_op,
   output logic [15:0] alu_result,
   output logic        c_out,
   output logic        lt,
   output logic        eq,
   output logic        gt,
   output logic        overflow,
   output logic [15:0] mem_rdata,
   output logic [15:0] wb_data,
   output logic        take_branch
);
`ifdef KURM_ALU_FLAGS_EN
   localparam bit FLAGS_EN = 1'b1;
`else
   localparam bit FLAGS_EN = 1'b0;
`endif
   localparam int AW = $clog2(DMEM_DEPTH);

   logic [15:0] b, bx, sum;
   logic        cy, sub, arith, lt_s, gt_s;
   logic [AW-1:0] idx;
   logic [15:0] mem_q [DMEM_DEPTH];
   logic [15:0] mem_d [DMEM_DEPTH];

   always_comb begin
      {reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write} = '0;
      alu_op = 3'b010;
      case (opcode)
         4'h0: {reg_dst, reg_write} = 2'b11;
         4'h1: {reg_dst, reg_write, alu_op} = 5'b11_110;
         4'h2: {reg_dst, reg_write, alu_op} = 5'b11_000;
         4'h3: {reg_dst, reg_write, alu_op} = 5'b11_001;
         4'h4: {reg_dst, reg_write, alu_op} = 5'b11_111;
         4'h5: {alu_src, reg_write} = 2'b11;
         4'h6: {alu_src, mem_read, mem_to_reg, reg_write} = 4'hF;
         4'h7: {alu_src, mem_write} = 2'b11;
         4'h8: {branch, alu_op} = 4'b1_110;
         4'h9: jump = 1'b1;
         default: ;
      endcase
   end

   // Subtraction shares the adder as A + ~B + 1, so carry-out means "no borrow".
   assign b     = alu_src ? {{12{imm4[3]}}, imm4} : rt_data;
   assign sub   = alu_op == 3'b110;
   assign arith = sub || alu_op == 3'b010;
   assign bx    = sub ? ~b : b;
   assign {cy, sum} = {1'b0, rs_data} + {1'b0, bx} + {16'b0, sub | c_in};
   assign lt_s  = $signed(rs_data) < $signed(b);
   assign gt_s  = $signed(rs_data) > $signed(b);
   assign eq    = rs_data == b;

   always_comb begin
      alu_result = sum;
      case (alu_op)
         3'b000: alu_result = rs_data & b;
         3'b001: alu_result = rs_data | b;
         3'b011: alu_result = rs_data ^ b;
         3'b100: alu_result = ~(rs_data | b);
         3'b101: alu_result = b;
         3'b111: alu_result = {15'b0, lt_s};
         default: ;
      endcase
   end

   assign c_out       = FLAGS_EN & arith & cy;
   assign overflow    = FLAGS_EN & arith & (rs_data[15] == bx[15]) & (sum[15] != rs_data[15]);
   assign lt          = FLAGS_EN & lt_s;
   assign gt          = FLAGS_EN & gt_s;
   assign take_branch = branch & ~eq;

   assign idx = alu_result[AW:1];

   always_comb begin
      mem_d = mem_q;
      if (mem_write) mem_d[idx] = rt_data;
   end

   always_ff @(posedge clock or negedge clearN)
      if (!clearN) mem_q <= '{default: '0};
      else mem_q <= mem_d;

   assign mem_rdata = mem_read ? mem_q[idx] : 16'h0000;
   assign wb_data   = mem_to_reg ? mem_rdata : alu_result;
endmodule

// File: tb/tb_kurm_exec_unit.sv
// tb_kurm_exec_unit: directed vectors checked every cycle against an arithmetic
// reference model of decode, ALU and memory, plus hand-computed literal checks.
module tb_kurm_exec_unit;
   localparam int DEPTH = 64;
`ifdef KURM_ALU_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic clock = 1'b0, clearN = 1'b1, c_in = 1'b0;
   logic [3:0] opcode = 4'h0, imm4 = 4'h0;
   logic [15:0] rs_data = 16'h0, rt_data = 16'h0;
   logic reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
   logic [2:0] alu_op;
   logic [15:0] alu_result, mem_rdata, wb_data;
   logic c_out, lt, eq, gt, overflow, take_branch;
   int tests = 0, fails = 0;
   logic [15:0] mm [DEPTH];

   // {reg_dst,jump,branch,mem_read,mem_to_reg,alu_op[2:0],mem_write,alu_src,reg_write}
   logic [10:0] ctab [16] = '{
      11'b10000_010_001, 11'b10000_110_001, 11'b10000_000_001, 11'b10000_001_001,
      11'b10000_111_001, 11'b00000_010_011, 11'b00011_010_011, 11'b00000_010_110,
      11'b00100_110_000, 11'b01000_010_000, 11'b00000_010_000, 11'b00000_010_000,
      11'b00000_010_000, 11'b00000_010_000, 11'b00000_010_000, 11'b00000_010_000};

   kurm_exec_unit #(.DMEM_DEPTH(DEPTH)) dut (
      .clock(clock), .clearN(clearN), .opcode(opcode), .rs_data(rs_data),
      .rt_data(rt_data), .imm4(imm4), .c_in(c_in), .reg_dst(reg_dst), .jump(jump),
      .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
      .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
      .alu_op(alu_op), .alu_result(alu_result), .c_out(c_out), .lt(lt), .eq(eq),
      .gt(gt), .overflow(overflow), .mem_rdata(mem_rdata), .wb_data(wb_data),
      .take_branch(take_branch));

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] rt,
                                 input logic [3:0] im, input logic ci, output logic [15:0] res,
                                 output logic co, output logic ov, output logic lt_o,
                                 output logic gt_o, output logic eq_o);
      logic [10:0] c;
      logic [15:0] bb;
      int sa, sb, t;
      c  = ctab[op];
      bb = c[1] ? 16'($signed(im)) : rt;
      sa = int'($signed(a));
      sb = int'($signed(bb));
      co = 1'b0;
      ov = 1'b0;
      case (c[5:3])
         3'b000: res = a & bb;
         3'b001: res = a | bb;
         3'b010: begin
            t   = int'(a) + int'(bb) + int'(ci);
            res = 16'(t);
            co  = t > 65535;
            ov  = (sa + sb + int'(ci) > 32767) || (sa + sb + int'(ci) < -32768);
         end
         3'b011: res = a ^ bb;
         3'b100: res = ~(a | bb);
         3'b101: res = bb;
         3'b110: begin
            res = a - bb;
            co  = a >= bb;
            ov  = (sa - sb > 32767) || (sa - sb < -32768);
         end
         default: res = (sa < sb) ? 16'd1 : 16'd0;
      endcase
      lt_o = sa < sb;
      gt_o = sa > sb;
      eq_o = a == bb;
      if (!FL) {co, ov, lt_o, gt_o} = 4'b0;
   endfunction

   always @(posedge clock or negedge clearN) begin : mem_model
      logic [15:0] r;
      logic co, ov, l, g, e;
      if (!clearN) begin
         for (int i = 0; i < DEPTH; i++) mm[i] <= 16'h0;
      end else if (ctab[opcode][2]) begin
         model(opcode, rs_data, rt_data, imm4, c_in, r, co, ov, l, g, e);
         mm[(r >> 1) % DEPTH] <= rt_data;
      end
   end

   always @(negedge clock) begin : cmp
      logic [15:0] r, rd;
      logic co, ov, l, g, e;
      logic [10:0] c;
      model(opcode, rs_data, rt_data, imm4, c_in, r, co, ov, l, g, e);
      c  = ctab[opcode];
      rd = c[7] ? mm[(r >> 1) % DEPTH] : 16'h0;
      chk("ctrl", {21'b0, reg_dst, jump, branch, mem_read, mem_to_reg, alu_op,
                   mem_write, alu_src, reg_write}, {21'b0, c});
      chk("alu_result", {16'b0, alu_result}, {16'b0, r});
      chk("flags", {27'b0, c_out, overflow, lt, gt, eq}, {27'b0, co, ov, l, g, e});
      chk("mem_rdata", {16'b0, mem_rdata}, {16'b0, rd});
      chk("wb_data", {16'b0, wb_data}, {16'b0, c[6] ? rd : r});
      chk("take_branch", {31'b0, take_branch}, {31'b0, c[8] & ~e});
   end

   task automatic step(input logic [3:0] op, input logic [15:0] a, input logic [15:0] rt,
                       input logic [3:0] im, input logic ci);
      @(posedge clock);
      #1;
      opcode = op; rs_data = a; rt_data = rt; imm4 = im; c_in = ci;
      @(negedge clock);
      #1;
   endtask

   initial begin
      #1 clearN = 1'b0;
      opcode = 4'h6;
      #1 chk("reset_rdata", {16'b0, mem_rdata}, 32'h0);
      repeat (2) @(negedge clock);
      #2 clearN = 1'b1;

      step(4'h0, 16'h7FFF, 16'h0001, 4'h0, 1'b0);
      chk("add_ovf_result", {16'b0, alu_result}, 32'h8000);
      chk("add_ovf_flags", {30'b0, overflow, c_out}, {30'b0, FL, 1'b0});
      chk("add_ctrl", {30'b0, reg_write, reg_dst}, 32'h3);

      step(4'h5, 16'h0010, 16'h0000, 4'hF, 1'b0);
      chk("addi_result", {16'b0, alu_result}, 32'h000F);
      chk("addi_cout", {30'b0, c_out, alu_src}, {30'b0, FL, 1'b1});

      step(4'h7, 16'h0004, 16'hBEEF, 4'h2, 1'b0);
      step(4'h6, 16'h0004, 16'h0000, 4'h2, 1'b0);
      chk("lw_rdata", {16'b0, mem_rdata}, 32'hBEEF);
      chk("lw_wb", {16'b0, wb_data}, 32'hBEEF);
      step(4'h6, 16'h0007, 16'h0000, 4'h0, 1'b0);
      chk("lw_bit0", {16'b0, mem_rdata}, 32'hBEEF);

      step(4'h8, 16'h0005, 16'h0005, 4'h0, 1'b0);
      chk("bne_eq", {30'b0, eq, take_branch}, 32'h2);
      step(4'h8, 16'h0005, 16'h0006, 4'h0, 1'b0);
      chk("bne_taken", {30'b0, take_branch, lt}, {30'b0, 1'b1, FL});

      step(4'h1, 16'h0003, 16'h0005, 4'h0, 1'b0);
      chk("sub_borrow", {15'b0, c_out, alu_result}, 32'h0000FFFE);
      step(4'h1, 16'h8000, 16'h0001, 4'h0, 1'b0);
      chk("sub_ovf", {15'b0, overflow, alu_result}, {15'b0, FL, 16'h7FFF});
      step(4'h0, 16'hFFFF, 16'h0001, 4'h0, 1'b1);
      chk("add_cin", {15'b0, c_out, alu_result}, {15'b0, FL, 16'h0001});
      step(4'h4, 16'hFFFF, 16'h0001, 4'h0, 1'b0);
      chk("slt", {16'b0, alu_result}, 32'h0001);
      step(4'h4, 16'h0001, 16'hFFFF, 4'h0, 1'b0);
      chk("slt_false", {16'b0, alu_result}, 32'h0000);
      step(4'h2, 16'hF0F0, 16'hFF00, 4'h0, 1'b0);
      chk("and", {16'b0, alu_result}, 32'hF000);
      step(4'h3, 16'hF0F0, 16'hFF00, 4'h0, 1'b0);
      chk("or", {16'b0, alu_result}, 32'hFFF0);
      step(4'h9, 16'h0000, 16'h0000, 4'h0, 1'b0);
      chk("jump", {31'b0, jump}, 32'h1);

      step(4'h7, 16'h0080, 16'hABCD, 4'h0, 1'b0);
      step(4'h6, 16'h0000, 16'h0000, 4'h0, 1'b0);
      chk("addr_wrap", {16'b0, mem_rdata}, 32'hABCD);

      step(4'h7, 16'h0006, 16'h1234, 4'h0, 1'b0);
      step(4'h6, 16'h0006, 16'h0000, 4'h0, 1'b0);
      chk("w3_before", {16'b0, mem_rdata}, 32'h1234);
      clearN = 1'b0;
      #1 chk("w3_in_reset", {16'b0, mem_rdata}, 32'h0);
      #1 clearN = 1'b1;
      #1 chk("w3_after", {16'b0, mem_rdata}, 32'h0);
      step(4'h6, 16'h0000, 16'h0000, 4'h0, 1'b0);
      chk("wrap_cleared", {16'b0, mem_rdata}, 32'h0);

      step(4'hF, 16'h1234, 16'h5678, 4'h3, 1'b0);
      chk("nop_ctrl", {21'b0, reg_dst, jump, branch, mem_read, mem_to_reg, alu_op,
                       mem_write, alu_src, reg_write}, 32'h010);

      @(posedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
